// File: rtl/sad_pkg.sv
// Shared constants, collector state encoding and match record layout for the
// SAD match collector.
package sad_pkg;

    localparam int COORD_W    = 10;
    localparam int FRAME_ROWS = 480;
    localparam int ROW_W      = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_DRAIN   = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    typedef struct packed {
        logic [ROW_W-1:0]   row;
        logic [COORD_W-1:0] col;
    } match_rec_t;

endpackage

// File: rtl/match_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; the head is read
// straight from storage, so a push into an empty FIFO is visible next cycle.
module match_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot this cycle, so a push into a full FIFO is accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/sad_match_collector.sv
// Tags per-row SAD results with a row index, queues matches and streams them
// out over valid/ready, reporting match count and overflow at frame end.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for frame_start
//   COLLECT | accepting row results until the last row of the frame
//   DRAIN   | waiting for the consumer to empty the match FIFO
//   DONE    | one-cycle frame_done pulse, then back to IDLE
module sad_match_collector
    import sad_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               row_valid,
    input  logic               sad_status,
    input  logic [COORD_W-1:0] coordinate,
    output logic               match_valid,
    input  logic               match_ready,
    output logic [ROW_W-1:0]   match_row,
    output logic [COORD_W-1:0] match_col,
    output logic               busy,
    output logic               frame_done,
    output logic [CNT_W-1:0]   match_count,
    output logic               overflow
);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
    match_rec_t       push_rec, head_rec;

    assign fifo_pop = !fifo_empty && match_ready;
    assign push_rec = '{row: row_cnt_q, col: coordinate};

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        fifo_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d   = ST_COLLECT;
                    row_cnt_d = '0;
                    count_d   = '0;
                    ovf_d     = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (row_valid) begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (sad_status) begin
                        // Dropped matches still count toward match_count.
                        count_d = (count_q == '1) ? count_q : count_q + 1'b1;
                        if (!fifo_full || fifo_pop) begin
                            fifo_push = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (row_cnt_q == ROW_W'(FRAME_ROWS - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            row_cnt_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    match_fifo #(
        .WIDTH ($bits(match_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (push_rec),
        .pop   (fifo_pop),
        .dout  (head_rec),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Head fields are forced to zero while empty so storage contents never leak out.
    assign match_valid = !fifo_empty;
    assign match_row   = fifo_empty ? '0 : head_rec.row;
    assign match_col   = fifo_empty ? '0 : head_rec.col;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_DONE);
    assign match_count = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_sad_match_collector.sv
// Randomised bench for sad_match_collector against a queue-based frame model.
module tb_sad_match_collector;
    import sad_pkg::*;

    localparam int DEPTH = 8;
    localparam int NROWS = FRAME_ROWS;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               frame_start = 1'b0;
    logic               row_valid = 1'b0;
    logic               sad_status = 1'b0;
    logic [COORD_W-1:0] coordinate = '0;
    logic               match_ready = 1'b0;
    logic               match_valid;
    logic [ROW_W-1:0]   match_row;
    logic [COORD_W-1:0] match_col;
    logic               busy;
    logic               frame_done;
    logic [9:0]         match_count;
    logic               overflow;

    always #5 clk = ~clk;

    sad_match_collector #(.FIFO_DEPTH(DEPTH), .CNT_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .row_valid   (row_valid),
        .sad_status  (sad_status),
        .coordinate  (coordinate),
        .match_valid (match_valid),
        .match_ready (match_ready),
        .match_row   (match_row),
        .match_col   (match_col),
        .busy        (busy),
        .frame_done  (frame_done),
        .match_count (match_count),
        .overflow    (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef enum {M_IDLE, M_COLLECT, M_DRAIN, M_DONE} phase_t;
    phase_t      m_phase;
    int          m_rows;
    int          m_count;
    bit          m_ovf;
    logic [19:0] m_q[$];
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    int          done_pulses;
    int          early_done;
    int          stall_changes;
    int          rows_sent = NROWS;
    bit          timeout;
    bit          prev_stall;
    logic [19:0] prev_head;

    bit          row_ss[NROWS];
    logic [9:0]  row_co[NROWS];

    task automatic model_reset();
        m_phase = M_IDLE;
        m_rows  = 0;
        m_count = 0;
        m_ovf   = 1'b0;
        m_q.delete();
    endtask

    // Frame-level behaviour: queue of at most DEPTH records, popped on valid&ready.
    task automatic model_edge(input bit fs, input bit rv, input bit ss,
                              input logic [9:0] co, input bit rdy);
        int          sz;
        bit          pop;
        logic [19:0] rec;
        sz  = m_q.size();
        pop = (sz > 0) && rdy;
        rec = {ROW_W'(m_rows), co};
        if (pop) exp_q.push_back(m_q.pop_front());
        case (m_phase)
            M_IDLE: if (fs) begin
                m_phase = M_COLLECT;
                m_rows  = 0;
                m_count = 0;
                m_ovf   = 1'b0;
            end
            M_COLLECT: if (rv) begin
                if (ss) begin
                    if (m_count < 1023) m_count++;
                    if (sz < DEPTH || pop) m_q.push_back(rec);
                    else m_ovf = 1'b1;
                end
                if (m_rows == NROWS - 1) m_phase = M_DRAIN;
                m_rows++;
            end
            M_DRAIN: if (sz == 0) m_phase = M_DONE;
            M_DONE:  m_phase = M_IDLE;
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic tick(input bit fs, input bit rv, input bit ss,
                        input logic [9:0] co, input bit rdy);
        @(negedge clk);
        frame_start = fs;
        row_valid   = rv;
        sad_status  = ss;
        coordinate  = co;
        match_ready = rdy;
        #1;
        if (match_valid && match_ready) obs_q.push_back({match_row, match_col});
        if (frame_done) begin
            done_pulses++;
            if (rows_sent < NROWS) early_done++;
        end
        if (prev_stall && ({match_row, match_col} !== prev_head)) stall_changes++;
        prev_stall = match_valid && !match_ready;
        prev_head  = {match_row, match_col};
        @(posedge clk);
        model_edge(fs, rv, ss, co, rdy);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst         = 1'b0;
        frame_start = 1'b0;
        row_valid   = 1'b0;
        sad_status  = 1'b0;
        match_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        obs_q.delete();
        exp_q.delete();
        done_pulses   = 0;
        early_done    = 0;
        stall_changes = 0;
        prev_stall    = 1'b0;
    endtask

    task automatic clear_rows();
        for (int r = 0; r < NROWS; r++) begin
            row_ss[r] = 1'b0;
            row_co[r] = 10'($urandom_range(1023));
        end
    endtask

    function automatic bit pick_rdy(input int mode, input int after, input int r);
        if (mode == 0) return 1'b1;
        if (mode == 1) return bit'($urandom_range(1));
        return (r >= after);
    endfunction

    task automatic play_frame(input int mode, input int after, input bit gaps, input bit fs_noise);
        int k;
        rows_sent = 0;
        timeout   = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 10'd0, pick_rdy(mode, after, 0));
        for (int r = 0; r < NROWS; r++) begin
            if (gaps && $urandom_range(3) == 0)
                tick(fs_noise && bit'($urandom_range(1)), 1'b0, 1'b0, 10'd0, pick_rdy(mode, after, r));
            tick(fs_noise && bit'($urandom_range(1)), 1'b1, row_ss[r], row_co[r], pick_rdy(mode, after, r));
            rows_sent = r + 1;
        end
        k = 0;
        while (m_phase != M_IDLE && k < 400) begin
            tick(1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
            k++;
        end
        if (k >= 400) timeout = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({busy, match_valid, frame_done, overflow, match_count} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%0b valid=%0b done=%0b ovf=%0b count=%0d, want all 0",
                     busy, match_valid, frame_done, overflow, match_count);
        end
        clear_rows();
        tick(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        for (int r = 0; r < 3; r++) tick(1'b0, 1'b1, 1'b1, 10'(r + 10), 1'b0);
        tick(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        n_tests++;
        if (match_count !== 10'd3 || match_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prefill: count=%0d valid=%0b, want 3 and 1", match_count, match_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, match_valid, overflow, match_count} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_async: busy=%0b valid=%0b ovf=%0b count=%0d, want all 0",
                     busy, match_valid, overflow, match_count);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if ({busy, match_valid, overflow, match_count} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_next_cycle: busy=%0b valid=%0b ovf=%0b count=%0d, want all 0",
                     busy, match_valid, overflow, match_count);
        end
        model_reset();
        prev_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 10'd0, 1'b1);
        n_tests++;
        if (match_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fifo_discard: valid=%0b busy=%0b, want 0 and 0", match_valid, busy);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        tick(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        n_tests++;
        if (match_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_start: valid=%0b busy=%0b, want 0 and 1", match_valid, busy);
        end
        tick(1'b0, 1'b1, 1'b1, 10'd77, 1'b0);
        n_tests++;
        if (match_valid !== 1'b1 || match_row !== 10'd0 || match_col !== 10'd77) begin
            n_fail++;
            $display("FAIL latency_head: valid=%0b row=%0d col=%0d, want 1 0 77",
                     match_valid, match_row, match_col);
        end
    endtask

    task automatic test_single();
        logic [19:0] got;
        apply_reset();
        clear_rows();
        row_ss[5] = 1'b1;
        row_co[5] = 10'd123;
        play_frame(0, 0, 1'b1, 1'b0);
        got = (obs_q.size() > 0) ? obs_q[0] : 20'hFFFFF;
        n_tests++;
        if (obs_q.size() != 1 || got !== {10'd5, 10'd123}) begin
            n_fail++;
            $display("FAIL single_record: n=%0d first=%h, want 1 record %h", obs_q.size(), got, {10'd5, 10'd123});
        end
        n_tests++;
        if (done_pulses != 1 || timeout) begin
            n_fail++;
            $display("FAIL single_done: pulses=%0d timeout=%0b, want 1 and 0", done_pulses, timeout);
        end
        n_tests++;
        if (match_count !== 10'd1 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_status: count=%0d ovf=%0b busy=%0b, want 1 0 0", match_count, overflow, busy);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        clear_rows();
        for (int r = 0; r < 4; r++) row_ss[r] = 1'b1;
        play_frame(2, 100, 1'b1, 1'b0);
        n_tests++;
        if (obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d records, want 4", obs_q.size());
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== {10'(i), row_co[i]}) begin
                n_fail++;
                $display("FAIL bp_record%0d: got %h want %h", i, obs_q[i], {10'(i), row_co[i]});
            end
        end
        n_tests++;
        if (stall_changes != 0 || done_pulses != 1 || match_count !== 10'd4) begin
            n_fail++;
            $display("FAIL bp_stable: changes=%0d pulses=%0d count=%0d, want 0 1 4",
                     stall_changes, done_pulses, match_count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        clear_rows();
        for (int r = 0; r < 12; r++) row_ss[r] = 1'b1;
        play_frame(2, 470, 1'b1, 1'b0);
        n_tests++;
        if (obs_q.size() != 8) begin
            n_fail++;
            $display("FAIL ovf_delivered: got %0d records, want 8", obs_q.size());
        end
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== {10'(i), row_co[i]}) begin
                n_fail++;
                $display("FAIL ovf_record%0d: got %h want %h", i, obs_q[i], {10'(i), row_co[i]});
            end
        end
        n_tests++;
        if (overflow !== 1'b1 || match_count !== 10'd12) begin
            n_fail++;
            $display("FAIL ovf_status: ovf=%0b count=%0d, want 1 and 12", overflow, match_count);
        end
    endtask

    task automatic test_push_pop();
        apply_reset();
        clear_rows();
        for (int r = 0; r < 10; r++) row_ss[r] = 1'b1;
        play_frame(2, 8, 1'b0, 1'b0);
        n_tests++;
        if (overflow !== 1'b0 || match_count !== 10'd10 || obs_q.size() != 10) begin
            n_fail++;
            $display("FAIL pp_status: ovf=%0b count=%0d n=%0d, want 0 10 10", overflow, match_count, obs_q.size());
        end
        for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== {10'(i), row_co[i]}) begin
                n_fail++;
                $display("FAIL pp_record%0d: got %h want %h", i, obs_q[i], {10'(i), row_co[i]});
            end
        end
    endtask

    task automatic test_control();
        apply_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 10'($urandom_range(1023)), 1'b1);
        n_tests++;
        if (busy !== 1'b0 || match_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_idle_rows: busy=%0b valid=%0b, want 0 and 0", busy, match_valid);
        end
        clear_rows();
        for (int r = 0; r < NROWS; r++) row_ss[r] = ($urandom_range(3) == 0);
        play_frame(1, 0, 1'b1, 1'b1);
        n_tests++;
        if (early_done != 0 || done_pulses != 1 || timeout) begin
            n_fail++;
            $display("FAIL ctrl_done: early=%0d pulses=%0d timeout=%0b, want 0 1 0", early_done, done_pulses, timeout);
        end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ctrl_count: got %0d records, want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ctrl_record%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (match_count !== 10'(m_count) || overflow !== m_ovf || stall_changes != 0) begin
            n_fail++;
            $display("FAIL ctrl_status: count=%0d ovf=%0b changes=%0d, want %0d %0b 0",
                     match_count, overflow, stall_changes, m_count, m_ovf);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int f = 0; f < 2; f++) begin
            clear_rows();
            for (int r = 0; r < NROWS; r++) row_ss[r] = bit'($urandom_range(1));
            done_pulses = 0;
            play_frame(1, 0, 1'b1, 1'b0);
            n_tests++;
            if (match_count !== 10'(m_count) || overflow !== m_ovf || done_pulses != 1) begin
                n_fail++;
                $display("FAIL b2b_status%0d: count=%0d ovf=%0b pulses=%0d, want %0d %0b 1",
                         f, match_count, overflow, done_pulses, m_count, m_ovf);
            end
        end
        n_tests++;
        if (obs_q.size() != exp_q.size() || stall_changes != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d records changes=%0d, want %0d and 0",
                     obs_q.size(), stall_changes, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_record%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_single();
        test_backpressure();
        test_overflow();
        test_push_pop();
        test_control();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
